// File: rtl/data_cache_if.sv
// Load/store port and backing-memory handshake for data_cache.
// slave is the cache's view; master is the datapath/memory side.
interface data_cache_if #(
    parameter int NBITS = 8
) ();
    logic             MemRead;
    logic             MemWrite;
    logic [NBITS-1:0] Address;
    logic [NBITS-1:0] WriteData;
    logic             flush;
    logic [NBITS-1:0] ReadData;
    logic             busy;
    logic             mem_req;
    logic             mem_we;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic             mem_ack;
    logic [NBITS-1:0] mem_rdata;

    modport slave (
        input  MemRead, MemWrite, Address, WriteData, flush,
        input  mem_ack, mem_rdata,
        output ReadData, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output MemRead, MemWrite, Address, WriteData, flush,
        output mem_ack, mem_rdata,
        input  ReadData, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Stalls the controller via busy while a fill or store is in flight.
module data_cache #(
    parameter int NBITS  = 8,
    parameter int NLINES = 8
) (
    input  logic        clock,
    input  logic        reset,
    data_cache_if.slave bus,
    output logic [7:0]  hits,
    output logic [7:0]  misses
);
    localparam int IDX = $clog2(NLINES);
    localparam int TAG = NBITS - IDX;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t state_q, state_d;

    logic [NLINES-1:0] valid_q;
    logic [TAG-1:0]    tag_q  [NLINES];
    logic [NBITS-1:0]  data_q [NLINES];
    logic [NBITS-1:0]  rd_q;
    logic              flush_pend;

    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic [IDX-1:0] m_idx;
    logic           hit;
    logic           rd_req;
    logic           wr_req;
    logic           read_hit;
    logic           done;

    assign idx      = bus.Address[IDX-1:0];
    assign tag      = bus.Address[NBITS-1:IDX];
    assign m_idx    = bus.mem_addr[IDX-1:0];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign rd_req   = bus.MemRead && !bus.MemWrite;
    assign wr_req   = bus.MemWrite;
    // a same-cycle flush wins over the lookup
    assign read_hit = rd_req && hit && !bus.flush;
    assign done     = (state_q != IDLE) && bus.mem_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wr_req)                 state_d = WRITE;
                else if (rd_req && !read_hit) state_d = FILL;
            end
            FILL, WRITE: if (bus.mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.ReadData = rd_q;
        unique case (state_q)
            IDLE: begin
                if (wr_req) bus.busy = 1'b1;
                else if (rd_req) begin
                    if (read_hit) bus.ReadData = data_q[idx];
                    else          bus.busy     = 1'b1;
                end
            end
            FILL: begin
                bus.busy = !bus.mem_ack;
                if (bus.mem_ack) bus.ReadData = bus.mem_rdata;
            end
            WRITE: bus.busy = !bus.mem_ack;
            default: bus.busy = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            rd_q          <= '0;
            flush_pend    <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            hits          <= '0;
            misses        <= '0;
        end else if (state_q == IDLE) begin
            if (bus.flush) valid_q <= '0;
            if (wr_req) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= bus.Address;
                bus.mem_wdata <= bus.WriteData;
            end else if (rd_req) begin
                if (read_hit) begin
                    rd_q <= data_q[idx];
                    if (hits != 8'hFF) hits <= hits + 8'd1;
                end else begin
                    bus.mem_req  <= 1'b1;
                    bus.mem_we   <= 1'b0;
                    bus.mem_addr <= bus.Address;
                    if (misses != 8'hFF) misses <= misses + 8'd1;
                end
            end
        end else if (done) begin
            bus.mem_req <= 1'b0;
            if (state_q == FILL) begin
                valid_q[m_idx] <= 1'b1;
                rd_q           <= bus.mem_rdata;
            end
            // deferred flush lands after the fill, leaving that line invalid
            if (flush_pend || bus.flush) valid_q <= '0;
            flush_pend <= 1'b0;
        end else if (bus.flush) begin
            flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == IDLE && wr_req && hit) begin
            data_q[idx] <= bus.WriteData;
        end else if (state_q == FILL && bus.mem_ack) begin
            tag_q[m_idx]  <= bus.mem_addr[NBITS-1:IDX];
            data_q[m_idx] <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache.
// A small in-bench responder acks memory requests after a set delay.
module tb_data_cache;
    logic       clock;
    logic       reset;
    logic [7:0] hits;
    logic [7:0] misses;
    int         checks;
    int         failures;

    data_cache_if #(.NBITS(8)) bus ();

    data_cache #(.NBITS(8), .NLINES(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .hits   (hits),
        .misses (misses)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_inputs();
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Address   = 8'h00;
        bus.WriteData = 8'h00;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
    endtask

    // Drives one request from just after an edge until busy drops.
    task automatic access(
        input  logic       rd,
        input  logic       wr,
        input  logic [7:0] addr,
        input  logic [7:0] wd,
        input  int         dly,
        input  logic [7:0] rdata,
        input  logic       fl_fill,
        output int         bcnt,
        output logic [7:0] rdo,
        output logic       req_o,
        output logic       we_o,
        output logic [7:0] addr_o,
        output logic [7:0] wd_o
    );
        int fc;
        fc     = 0;
        bcnt   = 99;
        rdo    = 8'hxx;
        req_o  = 1'bx;
        we_o   = 1'bx;
        addr_o = 8'hxx;
        wd_o   = 8'hxx;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.Address   = addr;
        bus.WriteData = wd;
        for (int i = 0; i < 40; i++) begin
            #4;
            if (!bus.busy) begin
                bcnt   = i;
                rdo    = bus.ReadData;
                req_o  = bus.mem_req;
                we_o   = bus.mem_we;
                addr_o = bus.mem_addr;
                wd_o   = bus.mem_wdata;
                break;
            end
            @(posedge clock);
            #1;
            bus.mem_ack = 1'b0;
            bus.flush   = 1'b0;
            if (bus.mem_req) begin
                fc++;
                if (fl_fill && fc == 1) bus.flush = 1'b1;
                if (fc > dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
        end
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl busy=%b req=%b we=%b want 0 0 0",
                     bus.busy, bus.mem_req, bus.mem_we);
        end
        checks++;
        if (bus.ReadData !== 8'h00 || hits !== 8'h00 || misses !== 8'h00) begin
            failures++;
            $display("FAIL reset_data rd=%h hits=%h misses=%h want 00 00 00",
                     bus.ReadData, hits, misses);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_read_miss_hit();
        int b; logic [7:0] r, a, w; logic q, e;
        access(1, 0, 8'h13, 8'h00, 2, 8'h5A, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 3 || r !== 8'h5A) begin
            failures++;
            $display("FAIL miss_13 busy_cycles=%0d rd=%h want 3 5a", b, r);
        end
        checks++;
        if (misses !== 8'd1 || hits !== 8'd0) begin
            failures++;
            $display("FAIL miss_cnt misses=%0d hits=%0d want 1 0", misses, hits);
        end
        access(1, 0, 8'h13, 8'h00, 2, 8'hEE, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 0 || r !== 8'h5A || hits !== 8'd1) begin
            failures++;
            $display("FAIL hit_13 busy_cycles=%0d rd=%h hits=%0d want 0 5a 1",
                     b, r, hits);
        end
    endtask

    task automatic test_store();
        int b; logic [7:0] r, a, w; logic q, e;
        access(0, 1, 8'h13, 8'h77, 1, 8'h00, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 2 || q !== 1'b1 || e !== 1'b1 || a !== 8'h13 || w !== 8'h77) begin
            failures++;
            $display("FAIL store_bus busy_cycles=%0d req=%b we=%b addr=%h wd=%h want 2 1 1 13 77",
                     b, q, e, a, w);
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL store_req_drop req=%b want 0", bus.mem_req);
        end
        access(1, 0, 8'h13, 8'h00, 0, 8'hEE, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 0 || r !== 8'h77 || hits !== 8'd2 || misses !== 8'd1) begin
            failures++;
            $display("FAIL store_update busy_cycles=%0d rd=%h hits=%0d misses=%0d want 0 77 2 1",
                     b, r, hits, misses);
        end
        access(0, 1, 8'h40, 8'h11, 0, 8'h00, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 1 || a !== 8'h40 || w !== 8'h11 || misses !== 8'd1) begin
            failures++;
            $display("FAIL store_40 busy_cycles=%0d addr=%h wd=%h misses=%0d want 1 40 11 1",
                     b, a, w, misses);
        end
        access(1, 0, 8'h40, 8'h00, 0, 8'h11, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 1 || r !== 8'h11 || misses !== 8'd2) begin
            failures++;
            $display("FAIL no_alloc busy_cycles=%0d rd=%h misses=%0d want 1 11 2",
                     b, r, misses);
        end
    endtask

    task automatic test_conflict();
        int b; logic [7:0] r, a, w, m0; logic q, e;
        m0 = misses;
        access(1, 0, 8'h05, 8'h00, 0, 8'hA1, 0, b, r, q, e, a, w);
        access(1, 0, 8'h0D, 8'h00, 0, 8'hB2, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 1 || r !== 8'hB2 || a !== 8'h0D) begin
            failures++;
            $display("FAIL conflict_0d busy_cycles=%0d rd=%h addr=%h want 1 b2 0d", b, r, a);
        end
        access(1, 0, 8'h05, 8'h00, 0, 8'hA1, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 1 || r !== 8'hA1 || misses !== m0 + 8'd3) begin
            failures++;
            $display("FAIL conflict_05 busy_cycles=%0d rd=%h misses=%0d want 1 a1 %0d",
                     b, r, misses, m0 + 8'd3);
        end
    endtask

    task automatic test_flush();
        int b; logic [7:0] r, a, w; logic q, e;
        access(1, 0, 8'h21, 8'h00, 2, 8'hC3, 1, b, r, q, e, a, w);
        checks++;
        if (b !== 3 || r !== 8'hC3) begin
            failures++;
            $display("FAIL flush_fill busy_cycles=%0d rd=%h want 3 c3", b, r);
        end
        access(1, 0, 8'h21, 8'h00, 0, 8'hC3, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 1) begin
            failures++;
            $display("FAIL flush_21 busy_cycles=%0d want 1", b);
        end
        access(1, 0, 8'h13, 8'h00, 0, 8'h66, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 1 || r !== 8'h66) begin
            failures++;
            $display("FAIL flush_13 busy_cycles=%0d rd=%h want 1 66", b, r);
        end
        bus.flush = 1'b1;
        #4;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle busy=%b want 0", bus.busy);
        end
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        access(1, 0, 8'h21, 8'h00, 0, 8'h99, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 1 || r !== 8'h99) begin
            failures++;
            $display("FAIL flush_idle_21 busy_cycles=%0d rd=%h want 1 99", b, r);
        end
    endtask

    task automatic test_reset_write();
        bus.MemWrite  = 1'b1;
        bus.Address   = 8'h30;
        bus.WriteData = 8'h55;
        @(posedge clock);
        #1;
        idle_inputs();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre req=%b we=%b busy=%b want 1 1 1",
                     bus.mem_req, bus.mem_we, bus.busy);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || hits !== 8'd0) begin
            failures++;
            $display("FAIL rst_async req=%b busy=%b hits=%0d want 0 0 0",
                     bus.mem_req, bus.busy, hits);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hAB;
        @(posedge clock);
        #1;
        bus.mem_ack = 1'b0;
        #3;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.ReadData !== 8'h00
            || misses !== 8'd0) begin
            failures++;
            $display("FAIL late_ack req=%b busy=%b rd=%h misses=%0d want 0 0 00 0",
                     bus.mem_req, bus.busy, bus.ReadData, misses);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_both_and_saturate();
        int b; logic [7:0] r, a, w; logic q, e;
        access(1, 0, 8'h30, 8'h00, 0, 8'h10, 0, b, r, q, e, a, w);
        access(1, 1, 8'h30, 8'h44, 0, 8'h00, 0, b, r, q, e, a, w);
        checks++;
        if (b !== 1 || e !== 1'b1 || w !== 8'h44 || hits !== 8'd0 || misses !== 8'd1) begin
            failures++;
            $display("FAIL both_store busy_cycles=%0d we=%b wd=%h hits=%0d misses=%0d want 1 1 44 0 1",
                     b, e, w, hits, misses);
        end
        for (int i = 0; i < 255; i++)
            access(1, 0, 8'h30, 8'h00, 0, 8'h00, 0, b, r, q, e, a, w);
        checks++;
        if (hits !== 8'hFF || r !== 8'h44) begin
            failures++;
            $display("FAIL hits_255 hits=%h rd=%h want ff 44", hits, r);
        end
        access(1, 0, 8'h30, 8'h00, 0, 8'h00, 0, b, r, q, e, a, w);
        checks++;
        if (hits !== 8'hFF || b !== 0 || misses !== 8'd1) begin
            failures++;
            $display("FAIL hits_sat hits=%h busy_cycles=%0d misses=%0d want ff 0 1",
                     hits, b, misses);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_read_miss_hit();
        test_store();
        test_conflict();
        test_flush();
        test_reset_write();
        test_both_and_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
